// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths and helpers for the ID/EX operand stage and its forwarding unit.
// Pure declarations: no logic, no timing.
package id_ex_operand_stage_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_CTRL_W = 8;
  localparam int HAZARD_W   = 16;

  localparam logic [HAZARD_W-1:0] HAZARD_MAX = '1;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [HAZARD_W-1:0] sat_inc(input logic [HAZARD_W-1:0] v);
    return (v == HAZARD_MAX) ? v : v + HAZARD_W'(1);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_forward.sv
// Per-operand bypass mux: EX result beats WB data beats register-file data.
// Purely combinational, zero latency, no flow control.
module operand_forward_unit
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_en,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] value
);

  // EX holds the younger producer, so it wins when both stages match.
  always_comb begin
    value = rf_data;
    if (ex_en && (ex_addr == addr)) begin
      value = ex_data;
    end else if (wb_en && (wb_addr == addr)) begin
      value = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register with EX/WB forwarding and a one-cycle load-use bubble.
// One cycle latency; ex_hold freezes the stage and asserts stall_id upstream.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [ADDR_W-1:0]   id_rs,
  input  logic [ADDR_W-1:0]   id_rd,
  input  logic [DATA_W-1:0]   id_ar,
  input  logic [DATA_W-1:0]   id_br,
  input  logic                id_use_rs,
  input  logic                id_use_rd,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [CTRL_W-1:0]   id_ctrl,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                wb_reg_write,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic                flush,
  input  logic                ex_hold,
  output logic                stall_id,
  output logic                ex_valid,
  output logic [DATA_W-1:0]   ex_a,
  output logic [DATA_W-1:0]   ex_b,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [CTRL_W-1:0]   ex_ctrl,
  output logic [ADDR_W-1:0]   ex_rd,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic [HAZARD_W-1:0] hazard_count
);

  logic [DATA_W-1:0]   fwd_a;
  logic [DATA_W-1:0]   fwd_b;
  logic                ex_fwd_en;
  logic                rs_hit;
  logic                rd_hit;
  logic                load_use;
  logic [HAZARD_W-1:0] hazard_q;

  // A load's ALU result is only an address, so it must never be forwarded.
  assign ex_fwd_en = ex_valid & ex_reg_write & ~ex_mem_read;

  assign rs_hit   = id_use_rs & (id_rs == ex_rd);
  assign rd_hit   = id_use_rd & (id_rd == ex_rd);
  assign load_use = id_valid & ex_valid & ex_mem_read & ex_reg_write & (rs_hit | rd_hit);
  assign stall_id = (load_use & ~flush & ~ex_hold) | ex_hold;

  operand_forward_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd_a (
    .addr    (id_rs),
    .rf_data (id_ar),
    .ex_en   (ex_fwd_en),
    .ex_addr (ex_rd),
    .ex_data (ex_result),
    .wb_en   (wb_reg_write),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .value   (fwd_a)
  );

  operand_forward_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwd_b (
    .addr    (id_rd),
    .rf_data (id_br),
    .ex_en   (ex_fwd_en),
    .ex_addr (ex_rd),
    .ex_data (ex_result),
    .wb_en   (wb_reg_write),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .value   (fwd_b)
  );

  // Write/load flags are stored already gated by valid so bubbles never look like producers.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_imm       <= '0;
      ex_ctrl      <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      hazard_q     <= '0;
    end else if (ex_hold) begin
      ex_valid     <= ex_valid;
    end else if (flush || load_use) begin
      ex_valid     <= 1'b0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_imm       <= '0;
      ex_ctrl      <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      if (!flush) begin
        hazard_q <= sat_inc(hazard_q);
      end
    end else begin
      ex_valid     <= id_valid;
      ex_a         <= fwd_a;
      ex_b         <= fwd_b;
      ex_imm       <= id_imm;
      ex_ctrl      <= id_ctrl;
      ex_rd        <= id_rd;
      ex_reg_write <= id_valid & id_reg_write;
      ex_mem_read  <= id_valid & id_mem_read;
    end
  end

  assign hazard_count = hazard_q;

endmodule
